// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversample tick, start-bit validation, LSB-first byte
// assembly, and a one-entry valid/ready output buffer with framing/overrun flags.
module uart_rx_ctrl #(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Din,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 Valid,
    input  logic                 Ready,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 Busy,
    output logic [1:0]           StateDbg_o
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] SMP_MID   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // Handshake: the byte on DataOut is transferred at a Clk edge where Valid && Ready;
    // Valid stays high and DataOut stays stable until then (or until a same-edge reload).

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

    state_e               state_q, state_d;
    logic                 din_s1_q, din_s_q, din_d_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]        smp_cnt_q, smp_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 fall, tick, busy;

    assign fall = din_d_q & ~din_s_q;
    assign tick = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);

    // State register plus datapath registers; synchronizer resets to the idle-high level
    // so leaving reset never looks like a start edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            din_s1_q   <= 1'b1;
            din_s_q    <= 1'b1;
            din_d_q    <= 1'b1;
            tick_cnt_q <= '0;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            din_s1_q   <= Din;
            din_s_q    <= din_s1_q;
            din_d_q    <= din_s_q;
            tick_cnt_q <= tick_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall) state_d = START;
            START:   if (tick && smp_cnt_q == SMP_MID) state_d = din_s_q ? IDLE : DATA;
            DATA:    if (tick && smp_cnt_q == SMP_LAST && bit_cnt_q == BIT_LAST) state_d = STOP;
            STOP:    if (tick && smp_cnt_q == SMP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        tick_cnt_d = (!busy || tick) ? '0 : tick_cnt_q + 1'b1;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        ferr_d     = 1'b0;
        valid_d    = valid_q && !Ready;
        ovr_d      = ovr_q && !(valid_q && Ready);
        case (state_q)
            IDLE: if (fall) smp_cnt_d = '0;
            START: if (tick) begin
                smp_cnt_d = smp_cnt_q + 1'b1;
                if (smp_cnt_q == SMP_MID && !din_s_q) begin
                    smp_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            DATA: if (tick) begin
                smp_cnt_d = smp_cnt_q + 1'b1;
                if (smp_cnt_q == SMP_LAST) begin
                    smp_cnt_d = '0;
                    shift_d   = {din_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                end
            end
            STOP: if (tick) begin
                smp_cnt_d = smp_cnt_q + 1'b1;
                if (smp_cnt_q == SMP_LAST) begin
                    smp_cnt_d = '0;
                    // A full buffer only loads if it is being drained on this same edge.
                    if (!din_s_q) ferr_d = 1'b1;
                    else if (!valid_q || Ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else ovr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign DataOut    = data_q;
    assign Valid      = valid_q;
    assign FrameErr   = ferr_q;
    assign Overrun    = ovr_q;
    assign Busy       = busy;
    assign StateDbg_o = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int BD  = 2;
  localparam int OV  = 16;
  localparam int DB  = 8;
  localparam int BIT = BD * OV;
  // Start edge -> Valid: 2 sync flops + edge flop, then OV/2 + OV*(DB+1) ticks of BD cycles.
  localparam int DET = 3;
  localparam int LAT = DET + BD * (OV / 2 + OV * (DB + 1));

  logic         Clk = 1'b0;
  logic         Rst, Din, Ready;
  logic [DB-1:0] DataOut;
  logic         Valid, FrameErr, Overrun, Busy;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  logic [DB-1:0] got_q[$];
  logic [DB-1:0] exp_q[$];

  uart_rx_ctrl #(.BAUD_DIV(BD), .OVERSAMPLE(OV), .DATA_BITS(DB)) dut (
    .Clk(Clk), .Rst(Rst), .Din(Din), .DataOut(DataOut), .Valid(Valid), .Ready(Ready),
    .FrameErr(FrameErr), .Overrun(Overrun), .Busy(Busy), .StateDbg_o(state_dbg)
  );

  always #5 Clk = ~Clk;

  // Monitor: records every accepted byte and every FrameErr cycle.
  always begin
    @(negedge Clk);
    #2;
    if (Rst === 1'b0) begin
      if (Valid && Ready) got_q.push_back(DataOut);
      if (FrameErr) ferr_cnt++;
    end
  end

  task automatic drive_bits(input logic v, input int n);
    Din = v;
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop);
    drive_bits(1'b0, BIT);
    for (int i = 0; i < DB; i++) drive_bits(b[i], BIT);
    drive_bits(stop, BIT);
  endtask

  task automatic test_reset();
    Rst = 1'b1; Din = 1'b1; Ready = 1'b1;
    repeat (3) @(negedge Clk);
    n_cmp++; if (DataOut !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", DataOut); end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", Valid); end
    n_cmp++; if (FrameErr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", FrameErr); end
    n_cmp++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b expected 0", Overrun); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    Rst = 1'b0;
    drive_bits(1'b1, 10);
  endtask

  task automatic test_good_frame();
    int g0 = got_q.size();
    int f0 = ferr_cnt;
    int valid_at = -1, busy_on = -1, busy_off = -1, vcyc = 0;
    Ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      for (int i = 1; i <= 330; i++) begin
        @(negedge Clk);
        if (Valid) begin vcyc++; if (valid_at < 0) valid_at = i; end
        if (Busy && busy_on < 0) busy_on = i;
        if (!Busy && busy_on >= 0 && busy_off < 0) busy_off = i;
      end
    join
    drive_bits(1'b1, 10);
    n_cmp++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL good_count: got %0d expected 1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      n_cmp++; if (got_q[g0] !== 8'hA5) begin n_err++; $display("FAIL good_data: got %h expected a5", got_q[g0]); end
    end
    n_cmp++; if (vcyc !== 1) begin n_err++; $display("FAIL good_valid_cycles: got %0d expected 1", vcyc); end
    n_cmp++; if (valid_at !== LAT) begin n_err++; $display("FAIL good_latency: got %0d expected %0d", valid_at, LAT); end
    n_cmp++; if (busy_on !== DET) begin n_err++; $display("FAIL good_busy_on: got %0d expected %0d", busy_on, DET); end
    n_cmp++; if (busy_off !== LAT) begin n_err++; $display("FAIL good_busy_off: got %0d expected %0d", busy_off, LAT); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL good_ferr: got %0d expected 0", ferr_cnt - f0); end
    n_cmp++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL good_ovr: got %b expected 0", Overrun); end
  endtask

  task automatic test_false_start();
    int g0 = got_q.size();
    int f0 = ferr_cnt;
    int busy_on = -1, busy_off = -1;
    fork
      begin drive_bits(1'b0, 10); drive_bits(1'b1, 40); end
      for (int i = 1; i <= 50; i++) begin
        @(negedge Clk);
        if (Busy && busy_on < 0) busy_on = i;
        if (!Busy && busy_on >= 0 && busy_off < 0) busy_off = i;
      end
    join
    n_cmp++; if (busy_on !== DET) begin n_err++; $display("FAIL false_busy_on: got %0d expected %0d", busy_on, DET); end
    n_cmp++; if (busy_off !== DET + BD * (OV / 2)) begin n_err++; $display("FAIL false_busy_off: got %0d expected %0d", busy_off, DET + BD * (OV / 2)); end
    n_cmp++; if (got_q.size() - g0 !== 0) begin n_err++; $display("FAIL false_valid: got %0d bytes expected 0", got_q.size() - g0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_err++; $display("FAIL false_ferr: got %0d expected 0", ferr_cnt - f0); end
    n_cmp++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL false_ovr: got %b expected 0", Overrun); end
  endtask

  task automatic test_framing();
    int g0 = got_q.size();
    int f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    drive_bits(1'b0, 60);
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL frame_ferr_width: got %0d cycles expected 1", ferr_cnt - f0); end
    n_cmp++; if (got_q.size() - g0 !== 0) begin n_err++; $display("FAIL frame_valid: got %0d bytes expected 0", got_q.size() - g0); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL frame_break_retrigger: got busy %b expected 0", Busy); end
    drive_bits(1'b1, 20);
    send_frame(8'h55, 1'b1);
    drive_bits(1'b1, 20);
    n_cmp++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL frame_next_count: got %0d expected 1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      n_cmp++; if (got_q[g0] !== 8'h55) begin n_err++; $display("FAIL frame_next_data: got %h expected 55", got_q[g0]); end
    end
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_err++; $display("FAIL frame_next_ferr: got %0d expected 1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun();
    int g0 = got_q.size();
    Ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive_bits(1'b1, 10);
    n_cmp++; if (Valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b expected 1", Valid); end
    n_cmp++; if (DataOut !== 8'h11) begin n_err++; $display("FAIL ovr_data: got %h expected 11", DataOut); end
    n_cmp++; if (Overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b expected 1", Overrun); end
    Ready = 1'b1;
    @(negedge Clk);
    Ready = 1'b0;
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL ovr_clear_valid: got %b expected 0", Valid); end
    n_cmp++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear_flag: got %b expected 0", Overrun); end
    @(negedge Clk);
    n_cmp++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL ovr_count: got %0d expected 1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      n_cmp++; if (got_q[g0] !== 8'h11) begin n_err++; $display("FAIL ovr_accepted: got %h expected 11", got_q[g0]); end
    end
  endtask

  task automatic test_same_cycle();
    int g0;
    Ready = 1'b0;
    send_frame(8'h0F, 1'b1);
    drive_bits(1'b1, 10);
    n_cmp++; if (DataOut !== 8'h0F || Valid !== 1'b1) begin n_err++; $display("FAIL same_hold: got %h/%b expected 0f/1", DataOut, Valid); end
    g0 = got_q.size();
    fork
      send_frame(8'hF0, 1'b1);
      begin repeat (LAT - 1) @(negedge Clk); Ready = 1'b1; @(negedge Clk); Ready = 1'b0; end
    join
    n_cmp++; if (DataOut !== 8'hF0) begin n_err++; $display("FAIL same_data: got %h expected f0", DataOut); end
    n_cmp++; if (Valid !== 1'b1) begin n_err++; $display("FAIL same_valid: got %b expected 1", Valid); end
    n_cmp++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL same_ovr: got %b expected 0", Overrun); end
    Ready = 1'b1;
    drive_bits(1'b1, 5);
    n_cmp++; if (got_q.size() - g0 !== 2) begin n_err++; $display("FAIL same_count: got %0d expected 2", got_q.size() - g0); end
    if (got_q.size() - g0 >= 2) begin
      n_cmp++; if (got_q[g0] !== 8'h0F || got_q[g0+1] !== 8'hF0) begin n_err++; $display("FAIL same_order: got %h,%h expected 0f,f0", got_q[g0], got_q[g0+1]); end
    end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL same_drain: got %b expected 0", Valid); end
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] b = 8'h99;
    int g0;
    Ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    drive_bits(1'b1, 10);
    drive_bits(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bits(b[i], BIT);
    drive_bits(b[4], 10);
    n_cmp++; if (Busy !== 1'b1 || Valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got busy %b valid %b expected 1 1", Busy, Valid); end
    Rst = 1'b1; Din = 1'b1;
    @(negedge Clk);
    n_cmp++; if (DataOut !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h expected 00", DataOut); end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", Valid); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
    n_cmp++; if (FrameErr !== 1'b0 || Overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_flags: got %b %b expected 0 0", FrameErr, Overrun); end
    Rst = 1'b0; Ready = 1'b1;
    drive_bits(1'b1, 20);
    g0 = got_q.size();
    send_frame(8'h42, 1'b1);
    drive_bits(1'b1, 20);
    n_cmp++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL rstmid_next_count: got %0d expected 1", got_q.size() - g0); end
    if (got_q.size() > g0) begin
      n_cmp++; if (got_q[g0] !== 8'h42) begin n_err++; $display("FAIL rstmid_next_data: got %h expected 42", got_q[g0]); end
    end
  endtask

  task automatic test_random();
    int g0 = got_q.size();
    int f0 = ferr_cnt;
    int exp_ferr = 0;
    logic [DB-1:0] b;
    logic ok;
    Ready = 1'b1;
    exp_q.delete();
    for (int n = 0; n < 10; n++) begin
      b  = DB'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if (ok) exp_q.push_back(b);
      else exp_ferr++;
      send_frame(b, ok);
      drive_bits(1'b1, $urandom_range(2, 30));
    end
    drive_bits(1'b1, 10);
    n_cmp++; if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d expected %0d", got_q.size() - g0, exp_q.size()); end
    for (int k = 0; k < exp_q.size() && g0 + k < got_q.size(); k++) begin
      n_cmp++; if (got_q[g0+k] !== exp_q[k]) begin n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", k, got_q[g0+k], exp_q[k]); end
    end
    n_cmp++; if (ferr_cnt - f0 !== exp_ferr) begin n_err++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr); end
    n_cmp++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL rand_ovr: got %b expected 0", Overrun); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
